// File: rtl/wb_pkg.sv
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared state encoding and load funct3 codes for writeback.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_COMMIT    = 2'd2
    } wb_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
//  Module   : load_align
//  Purpose  : Extracts and sign/zero-extends load data from an aligned word.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module load_align
    import wb_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] i_rdata,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_offset,
    output logic [DWIDTH-1:0] o_data
);

    logic [4:0]  w_bit_idx;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bit_idx = {i_offset, 3'b000};
    assign w_byte    = i_rdata[w_bit_idx +: 8];
    assign w_half    = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Unrecognised size codes fall through to a full-word load.
    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            LB:      o_data = {{(DWIDTH-8){w_byte[7]}}, w_byte};
            LBU:     o_data = {{(DWIDTH-8){1'b0}}, w_byte};
            LH:      o_data = {{(DWIDTH-16){w_half[15]}}, w_half};
            LHU:     o_data = {{(DWIDTH-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback.sv
// ============================================================================
//  Module   : writeback
//  Purpose  : Register-file writeback stage; commits ALU results and aligned
//             load data, tracking one outstanding load for hazard logic.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module writeback
    import wb_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_ex_valid,
    output logic              w_ex_ready,
    input  logic [AWIDTH-1:0] w_ex_rd,
    input  logic [DWIDTH-1:0] w_ex_result,
    input  logic              w_ex_is_load,
    input  logic [2:0]        w_ex_funct3,
    input  logic              w_mem_valid,
    input  logic [DWIDTH-1:0] w_mem_rdata,
    output logic              w_we,
    output logic [AWIDTH-1:0] w_addr_rd,
    output logic [DWIDTH-1:0] w_data_rd,
    output logic              w_pending_valid,
    output logic [AWIDTH-1:0] w_pending_rd
);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;

    logic [AWIDTH-1:0] r_ld_rd;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_offset;

    logic              r_we;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_data;

    logic              w_hs;
    logic              w_latch_load;
    logic              w_we_nxt;
    logic [AWIDTH-1:0] w_addr_nxt;
    logic [DWIDTH-1:0] w_data_nxt;
    logic [DWIDTH-1:0] w_aligned;

    load_align #(
        .DWIDTH (DWIDTH)
    ) u_load_align (
        .i_rdata  (w_mem_rdata),
        .i_funct3 (r_ld_funct3),
        .i_offset (r_ld_offset),
        .o_data   (w_aligned)
    );

    assign w_ex_ready = (r_state != ST_LOAD_WAIT);
    assign w_hs       = w_ex_valid && w_ex_ready;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state     <= ST_IDLE;
            r_ld_rd     <= '0;
            r_ld_funct3 <= '0;
            r_ld_offset <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            if (w_latch_load) begin
                r_ld_rd     <= w_ex_rd;
                r_ld_funct3 <= w_ex_funct3;
                r_ld_offset <= w_ex_result[1:0];
            end
        end
    end

    // Writes to x0 run the full handshake but never assert the write enable,
    // and leave the visible address/data untouched.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch_load = 1'b0;
        w_we_nxt     = 1'b0;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        case (r_state)
            ST_IDLE, ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                if (w_hs) begin
                    if (w_ex_is_load) begin
                        w_state_nxt  = ST_LOAD_WAIT;
                        w_latch_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_COMMIT;
                        if (w_ex_rd != '0) begin
                            w_we_nxt   = 1'b1;
                            w_addr_nxt = w_ex_rd;
                            w_data_nxt = w_ex_result;
                        end
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (w_mem_valid) begin
                    w_state_nxt = ST_COMMIT;
                    if (r_ld_rd != '0) begin
                        w_we_nxt   = 1'b1;
                        w_addr_nxt = r_ld_rd;
                        w_data_nxt = w_aligned;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_we            = r_we;
    assign w_addr_rd       = r_addr;
    assign w_data_rd       = r_data;
    assign w_pending_valid = (r_state == ST_LOAD_WAIT);
    assign w_pending_rd    = w_pending_valid ? r_ld_rd : '0;

endmodule

`default_nettype wire
